// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with 3-sample majority vote,
// configurable framing and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int FREQUENCY  = 130,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_i,
  output logic [DATA_BITS-1:0]          rx_data_o,
  output logic                          rx_par_err_o,
  output logic                          rx_frame_err_o,
  output logic                          rx_vld_o,
  input  logic                          rx_rdy_i,
  output logic [$clog2(FIFO_DEPTH):0]   rx_fill_o,
  output logic                          overrun_o,
  output logic                          break_o,
  input  logic                          clr_i,
  output logic                          rts_n_o
);

  localparam int DIV_RAW = (FREQUENCY * 1000000) / (BAUDRATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = $clog2(DIV) + 1;
  localparam int PW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int WW      = DATA_BITS + 2;
  localparam int HALF    = OVERSAMPLE / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_s1_q, rx_s1_d;
  logic                 rx_s2_q, rx_s2_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [1:0]           sv_q, sv_d;
  logic                 armed_q, armed_d;
  logic [DW-1:0]        div_q, div_d;
  logic [PW-1:0]        ph_q, ph_d;
  logic [1:0]           samp_q, samp_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frame_err_q, frame_err_d;

  logic [WW-1:0]        mem_q [FIFO_DEPTH];
  logic [WW-1:0]        mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          fill_q, fill_d;
  logic                 overrun_q, overrun_d;
  logic                 break_q, break_d;
  logic                 rts_n_q, rts_n_d;

  logic                 fall;
  logic                 tick;
  logic                 vote_now;
  logic                 bit_end;
  logic                 voted;
  logic                 par_exp;
  logic                 fe_now;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 push_ok;
  logic [WW-1:0]        wr_word;
  logic [WW-1:0]        head;

  // Sync flops idle high; armed_q keeps a line that is low at reset
  // release from being mistaken for a start edge.
  always_comb begin
    rx_s1_d   = rx_i;
    rx_s2_d   = rx_s1_q;
    rx_prev_d = rx_s2_q;
    sv_d      = {sv_q[0], 1'b1};
    armed_d   = armed_q | (sv_q[1] & rx_s2_q);
  end

  assign fall     = armed_q & rx_prev_q & ~rx_s2_q;
  assign tick     = (div_q == DW'(DIV - 1));
  assign vote_now = tick & (ph_q == PW'(HALF + 1));
  assign bit_end  = tick & (ph_q == PW'(OVERSAMPLE - 1));
  assign voted    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q)
                  | (samp_q[1] & rx_s2_q);
  assign par_exp  = (PARITY == 2) ? ~(^shift_q) : ^shift_q;
  assign fe_now   = frame_err_q | ~voted;
  assign wr_word  = {fe_now, par_err_q, shift_q};

  always_comb begin
    state_d     = state_q;
    div_d       = tick ? '0 : div_q + DW'(1);
    ph_d        = ph_q;
    samp_d      = samp_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    push        = 1'b0;
    if (tick) begin
      ph_d = bit_end ? '0 : ph_q + PW'(1);
      if (ph_q == PW'(HALF - 1)) samp_d[0] = rx_s2_q;
      if (ph_q == PW'(HALF))     samp_d[1] = rx_s2_q;
    end
    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d     = S_START;
          div_d       = '0;
          ph_d        = '0;
          bit_cnt_d   = '0;
          stop_cnt_d  = 1'b0;
          par_err_d   = 1'b0;
          frame_err_d = 1'b0;
        end
      end
      S_START: begin
        if (vote_now && voted) state_d = S_IDLE;
        else if (bit_end)      state_d = S_DATA;
      end
      S_DATA: begin
        if (vote_now) shift_d = {voted, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (vote_now) par_err_d = (voted != par_exp);
        if (bit_end)  state_d   = S_STOP;
      end
      S_STOP: begin
        if (vote_now) begin
          frame_err_d = fe_now;
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end else if (bit_end) begin
          stop_cnt_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop     = (fill_q != '0) & rx_rdy_i;
  assign full    = (fill_q == (AW+1)'(FIFO_DEPTH));
  assign push_ok = push & (~full | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fill_d   = fill_q;
    if (push_ok && !pop) fill_d = fill_q + (AW+1)'(1);
    if (!push_ok && pop) fill_d = fill_q - (AW+1)'(1);
    if (push_ok) mem_d[wr_ptr_q] = wr_word;
    // Set beats a coincident clear.
    overrun_d = clr_i ? 1'b0 : overrun_q;
    break_d   = clr_i ? 1'b0 : break_q;
    if (push && full && !pop) overrun_d = 1'b1;
    if (push && fe_now && (shift_q == '0)) break_d = 1'b1;
    rts_n_d = (fill_q >= (AW+1)'(FIFO_DEPTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      sv_q        <= '0;
      armed_q     <= 1'b0;
      div_q       <= '0;
      ph_q        <= '0;
      samp_q      <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      overrun_q   <= 1'b0;
      break_q     <= 1'b0;
      rts_n_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_prev_q   <= rx_prev_d;
      sv_q        <= sv_d;
      armed_q     <= armed_d;
      div_q       <= div_d;
      ph_q        <= ph_d;
      samp_q      <= samp_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      overrun_q   <= overrun_d;
      break_q     <= break_d;
      rts_n_q     <= rts_n_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head           = mem_q[rd_ptr_q];
  assign rx_vld_o       = (fill_q != '0);
  assign rx_data_o      = rx_vld_o ? head[DATA_BITS-1:0] : '0;
  assign rx_par_err_o   = rx_vld_o & head[DATA_BITS];
  assign rx_frame_err_o = rx_vld_o & head[DATA_BITS+1];
  assign rx_fill_o      = fill_q;
  assign overrun_o      = overrun_q;
  assign break_o        = break_q;
  assign rts_n_o        = rts_n_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: instance a is 8N1, instance b is 8E2,
// both at 16 clocks per bit.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       rx_a = 1'b1, rdy_a = 1'b1, clr_a = 1'b0;
  logic [7:0] data_a;
  logic       pe_a, fe_a, vld_a, ovr_a, brk_a, rts_a;
  logic [2:0] fill_a;

  logic       rx_b = 1'b1, rdy_b = 1'b1, clr_b = 1'b0;
  logic [7:0] data_b;
  logic       pe_b, fe_b, vld_b, ovr_b, brk_b, rts_b;
  logic [2:0] fill_b;

  int n_chk  = 0;
  int n_fail = 0;

  logic [9:0] q_a[$];
  logic [9:0] q_b[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .FREQUENCY(16), .BAUDRATE(1000000), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .rx_i(rx_a),
    .rx_data_o(data_a), .rx_par_err_o(pe_a), .rx_frame_err_o(fe_a),
    .rx_vld_o(vld_a), .rx_rdy_i(rdy_a), .rx_fill_o(fill_a),
    .overrun_o(ovr_a), .break_o(brk_a), .clr_i(clr_a), .rts_n_o(rts_a)
  );

  uart_rx_fifo #(
    .FREQUENCY(16), .BAUDRATE(1000000), .DATA_BITS(8), .PARITY(1),
    .STOP_BITS(2), .OVERSAMPLE(16), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .rx_i(rx_b),
    .rx_data_o(data_b), .rx_par_err_o(pe_b), .rx_frame_err_o(fe_b),
    .rx_vld_o(vld_b), .rx_rdy_i(rdy_b), .rx_fill_o(fill_b),
    .overrun_o(ovr_b), .break_o(brk_b), .clr_i(clr_b), .rts_n_o(rts_b)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive frame bits LSB first, 16 clocks each; gbit selects a bit
  // that gets a one-clock inverted glitch at clock 8.
  task automatic drive(input bit which, input logic [15:0] frame,
                       input int n, input int gbit);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 16; c++) begin
        if (which) rx_b = frame[i] ^ (i == gbit && c == 8);
        else       rx_a = frame[i] ^ (i == gbit && c == 8);
        @(negedge clk);
      end
    end
  endtask

  task automatic send_a(input logic [7:0] d, input int gbit);
    drive(1'b0, {5'b0, 1'b1, 1'b1, d, 1'b0}, 11, gbit);
  endtask

  task automatic send_b(input logic [7:0] d, input logic p,
                        input logic s1, input logic s2);
    drive(1'b1, {2'b0, 1'b1, s2, s1, p, d, 1'b0}, 13, -1);
  endtask

  always @(negedge clk) begin
    if (!rst && vld_a && rdy_a) begin
      n_chk++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL a_unexpected: got %0h expected none",
                 {fe_a, pe_a, data_a});
      end else begin
        logic [9:0] e;
        e = q_a.pop_front();
        if ({fe_a, pe_a, data_a} !== e) begin
          n_fail++;
          $display("FAIL a_word: got %0h expected %0h",
                   {fe_a, pe_a, data_a}, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && vld_b && rdy_b) begin
      n_chk++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL b_unexpected: got %0h expected none",
                 {fe_b, pe_b, data_b});
      end else begin
        logic [9:0] e;
        e = q_b.pop_front();
        if ({fe_b, pe_b, data_b} !== e) begin
          n_fail++;
          $display("FAIL b_word: got %0h expected %0h",
                   {fe_b, pe_b, data_b}, e);
        end
      end
    end
  end

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_vld", vld_a, 0);
    check("rst_fill", fill_a, 0);
    check("rst_data", data_a, 0);
    check("rst_pe", pe_a, 0);
    check("rst_fe", fe_a, 0);
    check("rst_ovr", ovr_a, 0);
    check("rst_brk", brk_a, 0);
    check("rst_rts", rts_a, 0);
    repeat (20) @(negedge clk);

    q_a.push_back({2'b00, 8'hA5});
    send_a(8'hA5, -1);
    repeat (16) @(negedge clk);
    check("a5_drained", fill_a, 0);

    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_a = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_fill", fill_a, 0);

    q_a.push_back({2'b00, 8'h55});
    send_a(8'h55, 2);
    repeat (16) @(negedge clk);

    rdy_a = 1'b0;
    send_a(8'h01, -1);
    send_a(8'h02, -1);
    check("ovf_fill2", fill_a, 2);
    check("ovf_rts2", rts_a, 0);
    send_a(8'h03, -1);
    check("ovf_fill3", fill_a, 3);
    check("ovf_rts3", rts_a, 1);
    send_a(8'h04, -1);
    check("ovf_ovr4", ovr_a, 0);
    send_a(8'h05, -1);
    check("ovf_fill4", fill_a, 4);
    check("ovf_ovr", ovr_a, 1);
    for (int i = 1; i <= 4; i++) q_a.push_back({2'b00, 8'(i)});
    rdy_a = 1'b1;
    repeat (10) @(negedge clk);
    check("ovf_empty", fill_a, 0);
    check("ovf_rts_lo", rts_a, 0);
    check("ovf_sticky", ovr_a, 1);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("ovf_clr", ovr_a, 0);

    q_b.push_back({2'b01, 8'h07});
    send_b(8'h07, 1'b0, 1'b1, 1'b1);
    q_b.push_back({2'b00, 8'h07});
    send_b(8'h07, 1'b1, 1'b1, 1'b1);
    q_b.push_back({2'b10, 8'h3C});
    send_b(8'h3C, 1'b0, 1'b1, 1'b0);
    check("b_nobrk", brk_b, 0);
    q_b.push_back({2'b10, 8'h00});
    drive(1'b1, 16'h1000, 13, -1);
    check("b_brk", brk_b, 1);
    check("b_ovr", ovr_b, 0);
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    check("b_brk_clr", brk_b, 0);

    rdy_a = 1'b0;
    send_a(8'h11, -1);
    send_a(8'h22, -1);
    check("mid_fill2", fill_a, 2);
    drive(1'b0, 16'h0018, 4, -1);
    rx_a = 1'b1;
    repeat (8) @(negedge clk);
    rx_a = 1'b0;
    rst = 1'b1;
    q_a.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_fill0", fill_a, 0);
    check("mid_vld0", vld_a, 0);
    repeat (20) @(negedge clk);
    rx_a = 1'b1;
    repeat (200) @(negedge clk);
    check("lowrel_fill", fill_a, 0);
    rdy_a = 1'b1;
    q_a.push_back({2'b00, 8'h3C});
    send_a(8'h3C, -1);

    repeat (50) @(negedge clk);
    check("a_drain", q_a.size(), 0);
    check("b_drain", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
